main_memory_model: RTL

//  Behavioural main-memory endpoint downstream of the multicore cache top (L2 miss/writeback port).

---
 rtl/main_memory_model_pkg.sv | 19 +
 rtl/main_memory_model_if.sv | 24 ++
 rtl/main_memory_model_mem_req_fifo.sv | 51 +++++
 rtl/main_memory_model.sv | 116 +++++++++++
 4 files changed

// File: rtl/main_memory_model_pkg.sv
// Shared memory-side definitions: address/line geometry, the request record
// exchanged with L2, and the service engine state encoding.
package main_memory_model_pkg;

  localparam int ADDR_BITS      = 8;
  localparam int OFFSET_BITS    = 2;
  localparam int CACHELINE_BITS = 1;
  localparam int LINE_ADDR_W    = ADDR_BITS - OFFSET_BITS;

  typedef struct packed {
    logic                      rw;
    logic [LINE_ADDR_W-1:0]    addr;
    logic [CACHELINE_BITS-1:0] data;
  } mem_req_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

endpackage

// File: rtl/main_memory_model_if.sv
// Request/response bus between the L2 miss/writeback port and main memory.
interface main_memory_model_if #(
  parameter int ADDR_W = main_memory_model_pkg::LINE_ADDR_W,
  parameter int DATA_W = main_memory_model_pkg::CACHELINE_BITS
);
  logic              mem_req_valid;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_data;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  logic              mem_busy;

  modport master (
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
    input  mem_req_ready, mem_resp_valid, mem_resp_data, mem_busy
  );

  modport slave (
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_data,
    output mem_req_ready, mem_resp_valid, mem_resp_data, mem_busy
  );
endinterface

// File: rtl/main_memory_model_mem_req_fifo.sv
// In-order request queue: power-of-two depth, wrapping pointers, occupancy
// count one bit wider than the pointers so full and empty are distinct.
module mem_req_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  slot_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) slot_q[wr_ptr_q] <= din;
  end

  assign full  = (count_q == (PW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = slot_q[rd_ptr_q];

endmodule

// File: rtl/main_memory_model.sv
// Behavioural main memory: queued line requests serviced one at a time with a
// fixed acceptance-to-completion latency; reads return a one-cycle response.
module main_memory_model
  import main_memory_model_pkg::*;
#(
  parameter int ADDR_W  = LINE_ADDR_W,
  parameter int DATA_W  = CACHELINE_BITS,
  parameter int LATENCY = 4,
  parameter int Q_DEPTH = 4
) (
  input logic                clk,
  input logic                reset,
  main_memory_model_if.slave bus
);
  localparam int CW     = $clog2(LATENCY);
  localparam int NLINES = 2 ** ADDR_W;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t              head;
  logic              push, pop, full, empty, wr_en;
  logic [0:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  req_t              svc_q, svc_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [DATA_W-1:0] store_q [NLINES];

  assign push = bus.mem_req_valid & ~full;

  mem_req_fifo #(.W($bits(req_t)), .DEPTH(Q_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   ({bus.mem_req_rw, bus.mem_req_addr, bus.mem_req_data}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // A pop from IDLE already spent one cycle noticing the queue, so it loads one
  // less than a pop chained straight off a completion; both give LATENCY spacing.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    svc_d        = svc_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    pop          = 1'b0;
    wr_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          svc_d   = head;
          cnt_d   = CW'(LATENCY - 2);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (svc_q.rw) begin
            wr_en = 1'b1;
          end else begin
            resp_valid_d = 1'b1;
            resp_data_d  = store_q[svc_q.addr];
          end
          if (!empty) begin
            pop   = 1'b1;
            svc_d = head;
            cnt_d = CW'(LATENCY - 1);
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      for (int i = 0; i < NLINES; i++) store_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      if (wr_en) store_q[svc_q.addr] <= svc_q.data;
    end
  end

  always_ff @(posedge clk) begin
    svc_q <= svc_d;
  end

  assign bus.mem_req_ready  = ~full;
  assign bus.mem_resp_valid = resp_valid_q;
  assign bus.mem_resp_data  = resp_data_q;
  assign bus.mem_busy       = ~empty | (state_q != ST_IDLE);

  a_resp_single_cycle: assert property (
    @(posedge clk) disable iff (reset) resp_valid_q |=> !resp_valid_q);

endmodule
